// File: rtl/add_sub_mod_serial_if.sv
// add_sub_mod_serial_if: operand/result bus of the word-serial modular adder/subtractor
// start, sub, a, b, p : controller -> adder (sampled when start is accepted)
// res, ready, valid   : adder -> controller
interface add_sub_mod_serial_if #(parameter int REG_SIZE = 384);
   logic                start;
   logic                sub;
   logic [REG_SIZE-1:0] a;
   logic [REG_SIZE-1:0] b;
   logic [REG_SIZE-1:0] p;
   logic [REG_SIZE-1:0] res;
   logic                ready;
   logic                valid;
   modport master (output start, sub, a, b, p, input res, ready, valid);
   modport slave (input start, sub, a, b, p, output res, ready, valid);
endinterface

// File: rtl/add_sub_mod_serial.sv
// add_sub_mod_serial: word-serial r = (a +/- b) mod p, RADIX bits per cycle, LSW first
// clk, reset (async, active-high); bus: add_sub_mod_serial_if slave
// Optional ADD_SUB_MOD_SERIAL_ZEROIZE_EN adds zeroize_i, a synchronous clear of all state
module add_sub_mod_serial #(
   parameter int REG_SIZE = 384,
   parameter int RADIX    = 32
) (
   input logic clk,
   input logic reset,
`ifdef ADD_SUB_MOD_SERIAL_ZEROIZE_EN
   input logic zeroize_i,
`endif
   add_sub_mod_serial_if.slave bus
);
   localparam int NUM_WORDS = REG_SIZE / RADIX;
   localparam int CW = $clog2(NUM_WORDS);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t              state, state_n;
   logic [REG_SIZE-1:0] a_q, b_q, p_q, s_q, t_q, res_q, s_next, t_next;
   logic [CW-1:0]       cnt;
   logic                sub_q, c1_q, c2_q, clr, last, pick_t;
   logic [RADIX:0]      s_full, t_full;
   logic [RADIX-1:0]    b_w, p_w;
`ifdef ADD_SUB_MOD_SERIAL_ZEROIZE_EN
   assign clr = zeroize_i;
`else
   assign clr = 1'b0;
`endif
   assign last   = cnt == CW'(NUM_WORDS - 1);
   assign b_w    = sub_q ? ~b_q[RADIX-1:0] : b_q[RADIX-1:0];
   assign p_w    = sub_q ? p_q[RADIX-1:0] : ~p_q[RADIX-1:0];
   assign s_full = {1'b0, a_q[RADIX-1:0]} + {1'b0, b_w} + {{RADIX{1'b0}}, c1_q};
   assign t_full = {1'b0, s_full[RADIX-1:0]} + {1'b0, p_w} + {{RADIX{1'b0}}, c2_q};
   assign s_next = {s_full[RADIX-1:0], s_q[REG_SIZE-1:RADIX]};
   assign t_next = {t_full[RADIX-1:0], t_q[REG_SIZE-1:RADIX]};
   // add: any carry out means a+b >= p, take T = S-p; sub: no borrow-free c1 means a<b, take T = S+p
   assign pick_t = sub_q ? ~s_full[RADIX] : (s_full[RADIX] | t_full[RADIX]);
   assign bus.res = res_q;
   always_comb begin
      state_n   = state;
      bus.ready = state == IDLE;
      bus.valid = state == DONE && !clr;
      state_n   = clr ? IDLE :
                  state == IDLE ? (bus.start ? RUN : IDLE) :
                  state == RUN ? (last ? DONE : RUN) : IDLE;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_n;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         a_q   <= '0;
         b_q   <= '0;
         p_q   <= '0;
         s_q   <= '0;
         t_q   <= '0;
         res_q <= '0;
         cnt   <= '0;
         sub_q <= 1'b0;
         c1_q  <= 1'b0;
         c2_q  <= 1'b0;
      end else if (clr) begin
         a_q   <= '0;
         b_q   <= '0;
         p_q   <= '0;
         s_q   <= '0;
         t_q   <= '0;
         res_q <= '0;
         cnt   <= '0;
         sub_q <= 1'b0;
         c1_q  <= 1'b0;
         c2_q  <= 1'b0;
      end else if (state == IDLE && bus.start) begin
         a_q   <= bus.a;
         b_q   <= bus.b;
         p_q   <= bus.p;
         sub_q <= bus.sub;
         cnt   <= '0;
         c1_q  <= bus.sub;
         c2_q  <= ~bus.sub;
      end else if (state == RUN) begin
         a_q  <= a_q >> RADIX;
         b_q  <= b_q >> RADIX;
         p_q  <= p_q >> RADIX;
         s_q  <= s_next;
         t_q  <= t_next;
         c1_q <= s_full[RADIX];
         c2_q <= t_full[RADIX];
         cnt  <= last ? cnt : cnt + CW'(1);
         if (last) res_q <= pick_t ? t_next : s_next;
      end
endmodule

// File: tb/tb_add_sub_mod_serial.sv
// tb_add_sub_mod_serial: directed and randomized checks of add_sub_mod_serial (REG_SIZE=16, RADIX=4)
module tb_add_sub_mod_serial;
   localparam int NW = 4;
   logic clk = 0;
   logic reset = 1;
   int   checks = 0;
   int   passed = 0;
   add_sub_mod_serial_if #(.REG_SIZE(16)) bus ();
`ifdef ADD_SUB_MOD_SERIAL_ZEROIZE_EN
   logic zeroize = 0;
   add_sub_mod_serial #(.REG_SIZE(16), .RADIX(4)) dut (.clk(clk), .reset(reset), .zeroize_i(zeroize), .bus(bus));
`else
   add_sub_mod_serial #(.REG_SIZE(16), .RADIX(4)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [15:0] ref_mod(input logic s, input logic [15:0] a, b, p);
      longint x;
      x = s ? (longint'(a) + longint'(p) - longint'(b)) : (longint'(a) + longint'(b));
      return 16'(x % longint'(p));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input string tag, input logic s, input logic [15:0] a, b, p, exp);
      int cyc;
      bus.start = 1; bus.sub = s; bus.a = a; bus.b = b; bus.p = p;
      tick();
      bus.start = 0; bus.sub = ~s; bus.a = 16'($urandom); bus.b = 16'($urandom); bus.p = 16'($urandom);
      check({tag, " busy"}, 32'(bus.ready), 0);
      cyc = 1;
      while (!bus.valid && cyc < 20) begin
         tick();
         cyc++;
      end
      check({tag, " latency"}, cyc, NW + 1);
      check({tag, " res"}, 32'(bus.res), 32'(exp));
      tick();
      check({tag, " valid pulse"}, 32'(bus.valid), 0);
      check({tag, " ready back"}, 32'(bus.ready), 1);
   endtask

   initial begin
      logic [15:0] ra, rb, rp;
      logic        rs;
      int          nv;
      logic [15:0] vres;
      bus.start = 0; bus.sub = 0; bus.a = 0; bus.b = 0; bus.p = 0;
      tick();
      check("reset res", 32'(bus.res), 0);
      check("reset ready", 32'(bus.ready), 1);
      check("reset valid", 32'(bus.valid), 0);
      tick();
      reset = 0;
      tick();
      check("idle ready", 32'(bus.ready), 1);
      do_op("add 5+3", 0, 16'h0005, 16'h0003, 16'hFFF1, 16'h0008);
      do_op("add c2", 0, 16'hFFF0, 16'h0002, 16'hFFF1, 16'h0001);
      do_op("add c1", 0, 16'hFFF0, 16'hFFF0, 16'hFFF1, 16'hFFEF);
      do_op("sub 3-5", 1, 16'h0003, 16'h0005, 16'hFFF1, 16'hFFEF);
      do_op("sub 5-5", 1, 16'h0005, 16'h0005, 16'hFFF1, 16'h0000);
      do_op("sub big", 1, 16'hFFF0, 16'h0001, 16'hFFF1, 16'hFFEF);
      // start pulses during RUN (cycle 2) and DONE (cycle 5) must be ignored
      bus.start = 1; bus.sub = 0; bus.a = 16'h1234; bus.b = 16'h0101; bus.p = 16'hFFF1;
      tick();
      nv = 0;
      vres = 16'hDEAD;
      for (int c = 1; c <= 12; c++) begin
         if (bus.valid) begin
            nv++;
            vres = bus.res;
         end
         bus.start = (c == 2 || c == 5);
         bus.sub = 1; bus.a = 16'h0007; bus.b = 16'h0009;
         tick();
      end
      bus.start = 0;
      check("ignore count", nv, 1);
      check("ignore res", 32'(vres), 32'h1335);
      check("ignore idle", 32'(bus.ready), 1);
      // asynchronous reset while word 2 is being processed
      bus.start = 1; bus.sub = 0; bus.a = 16'h00AA; bus.b = 16'h0011;
      tick();
      bus.start = 0;
      tick();
      tick();
      #2 reset = 1;
      #1;
      check("abort ready", 32'(bus.ready), 1);
      check("abort res", 32'(bus.res), 0);
      check("abort valid", 32'(bus.valid), 0);
      #1 reset = 0;
      tick();
      nv = 0;
      for (int c = 0; c < 8; c++) begin
         if (bus.valid) nv++;
         tick();
      end
      check("abort no valid", nv, 0);
      do_op("after abort", 0, 16'h0001, 16'h0001, 16'hFFF1, 16'h0002);
`ifdef ADD_SUB_MOD_SERIAL_ZEROIZE_EN
      bus.start = 1; bus.sub = 0; bus.a = 16'h0100; bus.b = 16'h0200;
      tick();
      bus.start = 0;
      tick();
      zeroize = 1;
      tick();
      zeroize = 0;
      check("zeroize ready", 32'(bus.ready), 1);
      check("zeroize res", 32'(bus.res), 0);
      nv = 0;
      for (int c = 0; c < 8; c++) begin
         if (bus.valid) nv++;
         tick();
      end
      check("zeroize no valid", nv, 0);
      zeroize = 1; bus.start = 1;
      tick();
      zeroize = 0; bus.start = 0;
      check("zeroize beats start", 32'(bus.ready), 1);
      tick();
      check("zeroize still idle", 32'(bus.ready), 1);
`endif
      for (int i = 0; i < 24; i++) begin
         rp = 16'($urandom_range(3, 65535)) | 16'h0001;
         ra = 16'($urandom_range(0, int'(rp) - 1));
         rb = (i % 4 == 0) ? ra : 16'($urandom_range(0, int'(rp) - 1));
         rs = 1'($urandom);
         do_op($sformatf("rand%0d", i), rs, ra, rb, rp, ref_mod(rs, ra, rb, rp));
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
